// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: registered one-hot grant with non-preemptive round-robin
// handoff, bounded bus locking, and address/data-phase master multiplexing.

`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif

module ahb_arbiter #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned LOCK_MAX    = 16,
    localparam int unsigned MW         = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_MASTERS-1:0]                  M_HReq,
    input  logic [NUM_MASTERS-1:0]                  M_HLock,
    input  logic [32*NUM_MASTERS-1:0]               M_HAddress,
    input  logic [NUM_MASTERS-1:0]                  M_HWrite,
    input  logic [`AHB_TRANS_BITS*NUM_MASTERS-1:0]  M_HTrans,
    input  logic [`AHB_SIZE_BITS*NUM_MASTERS-1:0]   M_HSize,
    input  logic [32*NUM_MASTERS-1:0]               M_HWrite_data,
    input  logic                                    HReady,
    output logic [NUM_MASTERS-1:0]                  HGrant,
    output logic [MW-1:0]                           HMaster,
    output logic [31:0]                             HAddress,
    output logic                                    HWrite,
    output logic [`AHB_TRANS_BITS-1:0]              HTrans,
    output logic [`AHB_SIZE_BITS-1:0]               HSize,
    output logic                                    HLock,
    output logic [31:0]                             HWrite_data
);

    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          master_q, master_d;
    // Data-phase owner (HMasterD): the address-phase owner delayed by one accepted transfer.
    logic [MW-1:0]          data_master_q, data_master_d;
    logic [CW-1:0]          lock_cnt_q, lock_cnt_d;

    logic                   others_req;
    logic                   lock_expired;
    logic                   found;
    logic [MW-1:0]          cand;
    int                     idx;

    // Grant, owner, data owner and lock counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q       <= {{(NUM_MASTERS-1){1'b0}}, 1'b1};
            master_q      <= '0;
            data_master_q <= '0;
            lock_cnt_q    <= '0;
        end else begin
            grant_q       <= grant_d;
            master_q      <= master_d;
            data_master_q <= data_master_d;
            lock_cnt_q    <= lock_cnt_d;
        end
    end

    // Arbitration: hold while requesting, keep while locked (until timeout), else round-robin.
    always_comb begin
        grant_d       = grant_q;
        master_d      = master_q;
        data_master_d = data_master_q;
        lock_cnt_d    = lock_cnt_q;
        found         = 1'b0;
        cand          = '0;
        idx           = 0;
        others_req    = |(M_HReq & ~grant_q);
        lock_expired  = (lock_cnt_q >= CW'(LOCK_MAX));

        if (HReady) begin
            data_master_d = master_q;
            if (M_HReq[master_q]) begin
                if (!others_req) begin
                    lock_cnt_d = '0;
                end
            end else if (M_HLock[master_q] && !lock_expired) begin
                lock_cnt_d = others_req ? lock_cnt_q + CW'(1) : '0;
            end else begin
                // Owner is idle here, so the search never lands back on it; no request parks.
                lock_cnt_d = '0;
                for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
                    idx = int'(master_q) + i;
                    if (idx >= int'(NUM_MASTERS)) begin
                        idx = idx - int'(NUM_MASTERS);
                    end
                    cand = MW'(idx);
                    if (!found && M_HReq[cand]) begin
                        found    = 1'b1;
                        master_d = cand;
                    end
                end
            end
            grant_d           = '0;
            grant_d[master_d] = 1'b1;
        end
    end

    // Address phase follows the current owner; data phase follows the previous one.
    always_comb begin
        HGrant      = grant_q;
        HMaster     = master_q;
        HAddress    = M_HAddress[int'(master_q)*32 +: 32];
        HWrite      = M_HWrite[master_q];
        HTrans      = M_HTrans[int'(master_q)*`AHB_TRANS_BITS +: `AHB_TRANS_BITS];
        HSize       = M_HSize[int'(master_q)*`AHB_SIZE_BITS +: `AHB_SIZE_BITS];
        HLock       = M_HLock[master_q];
        HWrite_data = M_HWrite_data[int'(data_master_q)*32 +: 32];
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, handoff, stall, lock timeout, data pipeline.

`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif

module tb_ahb_arbiter;

    localparam int unsigned N = 3;

    logic                              clk;
    logic                              rst;
    logic [N-1:0]                      M_HReq;
    logic [N-1:0]                      M_HLock;
    logic [32*N-1:0]                   M_HAddress;
    logic [N-1:0]                      M_HWrite;
    logic [`AHB_TRANS_BITS*N-1:0]      M_HTrans;
    logic [`AHB_SIZE_BITS*N-1:0]       M_HSize;
    logic [32*N-1:0]                   M_HWrite_data;
    logic                              HReady;
    logic [N-1:0]                      HGrant;
    logic [1:0]                        HMaster;
    logic [31:0]                       HAddress;
    logic                              HWrite;
    logic [`AHB_TRANS_BITS-1:0]        HTrans;
    logic [`AHB_SIZE_BITS-1:0]         HSize;
    logic                              HLock;
    logic [31:0]                       HWrite_data;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A0 = 32'h0000_0A00;
    localparam logic [31:0] A1 = 32'h0000_1000;
    localparam logic [31:0] A2 = 32'h0000_2000;
    localparam logic [31:0] D0 = 32'hD000_0000;
    localparam logic [31:0] D1 = 32'hD111_1111;
    localparam logic [31:0] D2 = 32'hD222_2222;

    ahb_arbiter #(
        .NUM_MASTERS(N),
        .LOCK_MAX   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .M_HReq       (M_HReq),
        .M_HLock      (M_HLock),
        .M_HAddress   (M_HAddress),
        .M_HWrite     (M_HWrite),
        .M_HTrans     (M_HTrans),
        .M_HSize      (M_HSize),
        .M_HWrite_data(M_HWrite_data),
        .HReady       (HReady),
        .HGrant       (HGrant),
        .HMaster      (HMaster),
        .HAddress     (HAddress),
        .HWrite       (HWrite),
        .HTrans       (HTrans),
        .HSize        (HSize),
        .HLock        (HLock),
        .HWrite_data  (HWrite_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        HReady        = 1'b1;
        M_HReq        = '0;
        M_HLock       = '0;
        M_HAddress    = {A2, A1, A0};
        M_HWrite_data = {D2, D1, D0};
        M_HWrite      = 3'b010;
        M_HTrans      = {2'b11, 2'b10, 2'b00};
        M_HSize       = {3'b001, 3'b010, 3'b000};

        // Reset
        step();
        step();
        check_eq("rst_grant", 32'(HGrant), 32'h1);
        check_eq("rst_master", 32'(HMaster), 32'h0);
        check_eq("rst_addr", HAddress, A0);
        check_eq("rst_trans", 32'(HTrans), 32'h0);
        check_eq("rst_wdata", HWrite_data, D0);
        rst = 1'b0;

        // Single request from master 1
        M_HReq = 3'b010;
        step();
        check_eq("single_grant", 32'(HGrant), 32'h2);
        check_eq("single_master", 32'(HMaster), 32'h1);
        check_eq("single_addr", HAddress, A1);
        check_eq("single_write", 32'(HWrite), 32'h1);
        check_eq("single_size", 32'(HSize), 32'h2);

        // Move ownership to master 0, then 0 idle with 1 and 2 requesting
        M_HReq = 3'b001;
        step();
        check_eq("to0_grant", 32'(HGrant), 32'h1);
        M_HReq = 3'b110;
        step();
        check_eq("rr_grant1", 32'(HGrant), 32'h2);
        M_HReq = 3'b100;
        step();
        check_eq("rr_grant2", 32'(HGrant), 32'h4);
        check_eq("rr_master2", 32'(HMaster), 32'h2);

        // Park with no requests
        M_HReq = 3'b000;
        step();
        check_eq("park_grant", 32'(HGrant), 32'h4);

        // Stall: owner 1 drops request while HReady=0
        M_HReq = 3'b010;
        step();
        check_eq("stall_setup", 32'(HGrant), 32'h2);
        HReady = 1'b0;
        M_HReq = 3'b100;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("stall_hold", 32'(HGrant), 32'h2);
        end
        HReady = 1'b1;
        step();
        check_eq("stall_release", 32'(HGrant), 32'h4);

        // Data pipeline: master 1 address phase accepted, then grant moves to 2
        M_HReq = 3'b010;
        step();
        step();
        check_eq("pipe_setup", 32'(HMaster), 32'h1);
        M_HReq = 3'b100;
        step();
        check_eq("pipe_master", 32'(HMaster), 32'h2);
        check_eq("pipe_wdata1", HWrite_data, D1);
        check_eq("pipe_addr2", HAddress, A2);
        step();
        check_eq("pipe_wdata2", HWrite_data, D2);

        // Hold rule with all requesting, then handoff search wrapping to 0
        M_HReq = 3'b111;
        step();
        check_eq("hold_grant", 32'(HGrant), 32'h4);
        M_HReq = 3'b011;
        step();
        check_eq("wrap_grant0", 32'(HGrant), 32'h1);

        // Lock: counter clears when the other request drops, then times out
        M_HReq  = 3'b100;
        M_HLock = 3'b001;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("lock_hold_a", 32'(HGrant), 32'h1);
        end
        check_eq("lock_out", 32'(HLock), 32'h1);
        M_HReq = 3'b000;
        step();
        check_eq("lock_noreq", 32'(HGrant), 32'h1);
        M_HReq = 3'b100;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("lock_hold_b", 32'(HGrant), 32'h1);
        end
        step();
        check_eq("lock_timeout", 32'(HGrant), 32'h4);
        check_eq("lock_tmaster", 32'(HMaster), 32'h2);

        // Reset while master 2 owns the bus
        step();
        rst = 1'b1;
        step();
        check_eq("mid_rst_grant", 32'(HGrant), 32'h1);
        check_eq("mid_rst_master", 32'(HMaster), 32'h0);
        check_eq("mid_rst_addr", HAddress, A0);
        check_eq("mid_rst_wdata", HWrite_data, D0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3, number of bus masters (2..8).
REQ-002 SHALL have parameter LOCK_MAX, default 16, maximum HReady cycles that a lock may hold the bus while another master is requesting.
REQ-003 SHALL define MW = max(1, clog2(NUM_MASTERS)).
REQ-004 SHALL have port clk, input, 1, single clock; all logic is synchronous to its posedge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port M_HReq, input, NUM_MASTERS, per-master bus request.
REQ-007 SHALL have port M_HLock, input, NUM_MASTERS, per-master lock request.
REQ-008 SHALL have port M_HAddress, input, 32*NUM_MASTERS, address; master i occupies bits [32i+31:32i].
REQ-009 SHALL have port M_HWrite, input, NUM_MASTERS, per-master write flag.
REQ-010 SHALL have port M_HTrans, input, `AHB_TRANS_BITS*NUM_MASTERS, transfer type, packed the same way as M_HAddress.
REQ-011 SHALL have port M_HSize, input, `AHB_SIZE_BITS*NUM_MASTERS, transfer size, packed the same way.
REQ-012 SHALL have port M_HWrite_data, input, 32*NUM_MASTERS, write data, packed the same way.
REQ-013 SHALL have port HReady, input, 1, bus transfer-complete from slave side.
REQ-014 SHALL have port HGrant, output, NUM_MASTERS, one-hot grant; broadcast HReady and HRead_data go to the masters externally.
REQ-015 SHALL have port HMaster, output, MW, index of the address-phase owner.
REQ-016 SHALL have outputs HAddress (32), HWrite (1), HTrans (`AHB_TRANS_BITS), HSize (`AHB_SIZE_BITS) and HLock (1), the muxed address-phase signals.
REQ-017 SHALL have output HWrite_data, 32, the muxed data-phase write data.

Function
REQ-018 HGrant SHALL be registered, always exactly one-hot, and HMaster SHALL equal the index of its set bit.
REQ-019 Grant SHALL be re-evaluated only at a posedge with HReady=1; with HReady=0, HGrant, HMaster and the lock counter SHALL hold.
REQ-020 Hold rule (non-preemptive): while the owner has M_HReq=1, the owner SHALL keep the grant.
REQ-021 Lock rule: while the owner has M_HLock=1, it SHALL keep the grant regardless of M_HReq, subject to REQ-023.
REQ-022 Handoff: when the owner is neither held nor locked, the grant SHALL go to the first master with M_HReq=1, searching cyclically from owner+1 (round-robin).
- If no master is requesting, the grant SHALL stay with the current owner (park).
REQ-023 Lock counter: SHALL increment at each HReady cycle in which the owner keeps the grant only via lock while another master requests.
- When the counter reaches LOCK_MAX, the lock SHALL be ignored for that evaluation and REQ-022 SHALL apply.
- The counter SHALL clear on every grant change and whenever no other master is requesting.
REQ-024 Address mux: HAddress, HWrite, HTrans, HSize and HLock SHALL combinationally select master HMaster.
REQ-025 Data mux: an internal register HMasterD SHALL load HMaster at each HReady=1 posedge, and HWrite_data SHALL combinationally select master HMasterD.
REQ-026 Simultaneous requests SHALL be resolved by REQ-022 only; the lowest index wins only when the search starts at 0.
REQ-027 A newly granted master asserting M_HReq SHALL retain the grant through its address phase until it drops M_HReq at an HReady=1 edge; a grant SHALL never be revoked while the owner's M_HReq=1.

Reset
REQ-028 With rst=1 at a posedge: HGrant=one-hot master 0, HMaster=0, HMasterD=0, lock counter=0.
REQ-029 Reset mid-transfer or mid-lock SHALL take effect on that same edge, abandoning the current ownership; muxed outputs then reflect master 0.

Verification
REQ-030 Reset: rst=1 for 2 cycles -> HGrant=3'b001, HMaster=0, HAddress=M_HAddress[0].
REQ-031 Single request: HReady=1, M_HReq=3'b010 at cycle 0 -> HGrant=3'b010 at cycle 1; HAddress=0x0000_1000 when M_HAddress[1]=0x0000_1000.
REQ-032 Round-robin: owner 0 idle, M_HReq=3'b110 -> grant 1; master 1 drops M_HReq with HReady=1 -> grant 2 on the next cycle.
REQ-033 Stall: owner 1 drops M_HReq while HReady=0 for 3 cycles with master 2 requesting -> HGrant=3'b010 held; it moves to 3'b100 one cycle after HReady=1.
REQ-034 Lock timeout (LOCK_MAX=4): master 0 with M_HLock=1, M_HReq=0 and master 2 requesting, HReady=1 -> grant moves to master 2 after 4 held cycles.
REQ-035 Data pipeline: master 1 address phase accepted at cycle n, grant moves to 2 -> at cycle n+1, HWrite_data=M_HWrite_data[1] while HMaster=2.
